// File: rtl/sum_arbiter_pkg.sv
// ============================================================================
// Module  : sum_arbiter_pkg
// Purpose : Shared types and defaults for the triangular-sum arbiter.
//           The engine FSM encoding and the default widths live here.
//           The widths are also shared with the sum/BCD display path.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_arbiter_pkg;

  // Engine FSM encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Default geometry. SUM_W >= 2*N_W guarantees the sum cannot overflow.
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_N_W     = 4;
  localparam int DEF_SUM_W   = 8;

endpackage

`default_nettype wire

// File: rtl/sum_arbiter_if.sv
// ============================================================================
// Module  : sum_arbiter_if
// Purpose : Request/result bundle between the requesters and the shared
//           triangular-sum engine.
// Signals : req       - per-requester request level
//           n_in      - packed N values, slice i belongs to req[i]
//           ack       - one-cycle accept pulse, one-hot
//           busy      - engine occupied (RUN or DONE)
//           res_valid - one-cycle result pulse
//           res_id    - owner of the result (held)
//           res_sum   - triangular sum (held)
// Modports: master (requester side), slave (engine side)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sum_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int N_W     = 4,
  parameter int SUM_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*N_W-1:0] n_in;
  logic [NUM_REQ-1:0]     ack;
  logic                   busy;
  logic                   res_valid;
  logic [ID_W-1:0]        res_id;
  logic [SUM_W-1:0]       res_sum;

  modport master (
    output req, n_in,
    input  ack, busy, res_valid, res_id, res_sum
  );

  modport slave (
    input  req, n_in,
    output ack, busy, res_valid, res_id, res_sum
  );
endinterface

`default_nettype wire

// File: rtl/sum_arbiter_rr.sv
// ============================================================================
// Module  : sum_arbiter_rr
// Purpose : Combinational round-robin arbiter. The winner is the first set
//           request scanning upward from ptr+1, wrapping through 0..ptr.
// Ports   : req_i     - request vector
//           ptr_i     - id of the last winner
//           grant_o   - one-hot grant
//           gid_o     - binary id of the grant
//           valid_o   - at least one request present
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_arbiter_rr #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req_i,
  input  wire logic [ID_W-1:0]    ptr_i,
  output logic      [NUM_REQ-1:0] grant_o,
  output logic      [ID_W-1:0]    gid_o,
  output logic                    valid_o
);

  // Two passes: ids above the pointer take precedence over the wrapped range.
  always_comb begin
    grant_o = '0;
    gid_o   = '0;
    valid_o = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!valid_o && req_i[j] && (ID_W'(j) > ptr_i)) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        gid_o      = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!valid_o && req_i[j] && (ID_W'(j) <= ptr_i)) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        gid_o      = ID_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sum_arbiter.sv
// ============================================================================
// Module  : sum_arbiter
// Purpose : Shares one iterative triangular-sum engine (S = 1+2+...+N)
//           between NUM_REQ requesters with round-robin arbitration and a
//           tagged one-cycle result pulse.
// Ports   : clk_i  - clock, rising edge
//           rst_ni - asynchronous active-low reset
//           bus    - sum_arbiter_if.slave (req/n_in in; ack/busy/res_* out)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_arbiter
  import sum_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int N_W     = DEF_N_W,
  parameter int SUM_W   = DEF_SUM_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input wire logic clk_i,
  input wire logic rst_ni,
  sum_arbiter_if.slave bus
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [N_W-1:0]     n_lat_q, n_lat_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   ctr_q, ctr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               res_valid_q, res_valid_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [SUM_W-1:0]   res_sum_q, res_sum_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               any_req;
  logic [N_W-1:0]     n_sel;

  sum_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .gid_o   (grant_id),
    .valid_o (any_req)
  );

  // Pick the N slice belonging to the one-hot winner.
  always_comb begin
    n_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        n_sel = bus.n_in[j*N_W +: N_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    n_lat_d     = n_lat_q;
    acc_d       = acc_q;
    ctr_d       = ctr_q;
    ack_d       = '0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          n_lat_d = n_sel;
          gid_d   = grant_id;
          ptr_d   = grant_id;
          ack_d   = grant;
          acc_d   = '0;
          ctr_d   = SUM_W'(1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // One addend per cycle; the first miss moves on to publish.
        if (ctr_q <= SUM_W'(n_lat_q)) begin
          acc_d = acc_q + ctr_q;
          ctr_d = ctr_q + SUM_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        res_sum_d   = acc_q;
        res_id_d    = gid_q;
        res_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer resets to the last id so requester 0 wins the first grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      gid_q       <= '0;
      n_lat_q     <= '0;
      acc_q       <= '0;
      ctr_q       <= '0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      n_lat_q     <= n_lat_d;
      acc_q       <= acc_d;
      ctr_q       <= ctr_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_sum   = res_sum_q;

endmodule

`default_nettype wire
